en_window_gen: RTL
==================

Name: en_window_gen

Overview:
- Parametrised enable-window generator; successor to the fixed 10-cycle enable counter.
- On a start request it emits cfg_num bursts, each holding en high for cfg_len cycles. Bursts are separated by cfg_gap low cycles.
- Supports single-shot or continuous mode, a level run gate that freezes progress, abort, and busy/done handshake.
- Drives downstream datapath enables in the integration experiments.

Parameters:
- LEN_W, 8, width of cfg_len and burst cycle counter
- GAP_W, 8, width of cfg_gap and gap counter
- NUM_W, 4, width of cfg_num and burst_idx

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- start  in  1  start request, sampled only in IDLE
- run  in  1  level gate; 0 freezes all counters/state in ON and GAP
- abort  in  1  terminate current sequence
- cfg_len  in  LEN_W  enable cycles per burst
- cfg_gap  in  GAP_W  low cycles between bursts
- cfg_num  in  NUM_W  bursts per sequence
- cfg_cont  in  1  1 = continuous repeat, 0 = single-shot
- en  out  1  registered enable window
- busy  out  1  high in ON and GAP
- done  out  1  one-cycle completion pulse
- burst_idx  out  NUM_W  index of current burst
- cnt  out  LEN_W  cycle count within current burst

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; en, busy, done, burst_idx, cnt and gap counter all 0. Reset mid-operation discards the sequence; no done pulse.
- All outputs are registered. busy and done decode the registered state.
- IDLE, start=1: latch cfg_len/gap/num/cont into len_q/gap_q/num_q/cont_q. cfg changes afterwards have no effect until the next start.
- IDLE, start=1, len_q=0 or num_q=0: go to DONE.
- IDLE, start=1, otherwise: go to ON with en<=1, cnt<=0, burst_idx<=0.
- Latency: en rises the cycle after start is sampled.
- ON, run=1, cnt != len_q-1: cnt<=cnt+1.
- ON, run=1, cnt == len_q-1 (end of burst): cnt<=0. Last burst means burst_idx == num_q-1.
  - Last burst and cont_q=0: en<=0, go to DONE.
  - Otherwise, next index is burst_idx+1, or 0 when wrapping after the last burst.
  - gap_q=0: stay in ON, en stays 1, burst_idx<=next. Back-to-back bursts have no low cycle.
  - gap_q>0: en<=0, gap counter<=0, go to GAP.
- GAP, run=1: gap counter increments.
- GAP, run=1, gap counter == gap_q-1: go to ON, en<=1, cnt<=0, burst_idx<=next.
- run=0 in ON/GAP: state, counters, burst_idx and en hold current values. run is ignored in IDLE/DONE.
- DONE: done=1 for exactly one cycle, then IDLE. en=0, busy=0.
- abort=1 in ON or GAP: next edge state=IDLE, en=0, counters 0; no done pulse. abort has priority over run and end-of-burst. abort in IDLE/DONE is ignored.
- start while not in IDLE is ignored. start on the same edge DONE returns to IDLE is ignored; start is accepted from the following cycle.
- len_q=1 gives a one-cycle en per burst.
- Counters compare against latched values minus 1 in their own width. Maximum values give 2^LEN_W-1 and 2^GAP_W-1 cycles; no wrap beyond.
- Priority per edge: reset > abort > run-freeze > normal transitions.

Test Plan:
- len=10, gap=0, num=1, cont=0, run=1, start pulse at edge 0 -> en=1 for cycles 1..10, cnt 0..9; done=1 in cycle 11 only; busy=1 cycles 1..10.
- len=3, gap=2, num=3, cont=0 -> en pattern 111 00 111 00 111, burst_idx 0,1,2 across bursts, then done for one cycle, then IDLE.
- len=4, num=1, run low for 3 cycles after 2nd en cycle -> en high 7 consecutive cycles, cnt holds at 1 during freeze, done follows.
- len=2, gap=1, num=2, cont=1 -> en 11 0 11 0 11..., burst_idx 0,1,0,1; no done. abort mid-burst -> en=0 and busy=0 next cycle, no done pulse.
- Zero and start cases:
  - cfg_len=0 -> en never rises; done one cycle after start.
  - Second start while busy -> ignored.
  - cfg_len changed mid-run -> current burst lengths unchanged.
- rst_n=0 for one edge mid-GAP -> all outputs 0 next cycle; new start afterwards runs a clean sequence from burst_idx 0.

Source files
------------

// File: rtl/en_window_gen.sv
// Enable-window generator: emits cfg_num bursts of cfg_len high cycles separated
// by cfg_gap low cycles, single-shot or continuous, with run gate, abort and done pulse.
module en_window_gen #(
    parameter int LEN_W = 8,
    parameter int GAP_W = 8,
    parameter int NUM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             run,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [NUM_W-1:0] cfg_num,
    input  logic             cfg_cont,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] burst_idx,
    output logic [LEN_W-1:0] cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [GAP_W-1:0] gap_q,     gap_d;
    logic [NUM_W-1:0] num_q,     num_d;
    logic             cont_q,    cont_d;
    logic             en_q,      en_d;
    logic [LEN_W-1:0] cnt_q,     cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [NUM_W-1:0] idx_q,     idx_d;

    // Terminal counts are computed in the counters' own widths, so a latched
    // maximum value yields 2^W-1 cycles without any wrap.
    logic [LEN_W-1:0] len_last;
    logic [GAP_W-1:0] gap_last;
    logic [NUM_W-1:0] num_last;
    logic [NUM_W-1:0] idx_next;
    logic             burst_end;
    logic             last_burst;

    assign len_last   = len_q - LEN_W'(1);
    assign gap_last   = gap_q - GAP_W'(1);
    assign num_last   = num_q - NUM_W'(1);
    assign burst_end  = (cnt_q == len_last);
    assign last_burst = (idx_q == num_last);
    assign idx_next   = last_burst ? '0 : idx_q + NUM_W'(1);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        len_d     = len_q;
        gap_d     = gap_q;
        num_d     = num_q;
        cont_d    = cont_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = cfg_len;
                    gap_d     = cfg_gap;
                    num_d     = cfg_num;
                    cont_d    = cfg_cont;
                    cnt_d     = '0;
                    gap_cnt_d = '0;
                    if (cfg_len == '0 || cfg_num == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ON;
                        en_d    = 1'b1;
                        idx_d   = '0;
                    end
                end
            end

            S_ON: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    en_d      = 1'b0;
                    cnt_d     = '0;
                    gap_cnt_d = '0;
                    idx_d     = '0;
                end else if (run) begin
                    if (!burst_end) begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (last_burst && !cont_q) begin
                            state_d = S_DONE;
                            en_d    = 1'b0;
                        end else if (gap_q == '0) begin
                            idx_d = idx_next;
                        end else begin
                            state_d   = S_GAP;
                            en_d      = 1'b0;
                            gap_cnt_d = '0;
                        end
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    en_d      = 1'b0;
                    cnt_d     = '0;
                    gap_cnt_d = '0;
                    idx_d     = '0;
                end else if (run) begin
                    if (gap_cnt_q == gap_last) begin
                        state_d   = S_ON;
                        en_d      = 1'b1;
                        cnt_d     = '0;
                        gap_cnt_d = '0;
                        idx_d     = idx_next;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end

            default: begin
                // DONE lasts one cycle; a start seen here is deliberately dropped.
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            gap_q     <= '0;
            num_q     <= '0;
            cont_q    <= 1'b0;
            en_q      <= 1'b0;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            num_q     <= num_d;
            cont_q    <= cont_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
        end
    end

    assign en        = en_q;
    assign busy      = (state_q == S_ON) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);
    assign burst_idx = idx_q;
    assign cnt       = cnt_q;

endmodule
